// File: rtl/clk_prog_pkg.sv
// Shared definitions for the DCM_CLKGEN serial programmer.
//   - prog_state_e : sequencer states
//   - CMD_LOAD_D / CMD_LOAD_M : 2-bit command headers, bit0 is shifted first
//   - LOAD_LEN : bits per LoadD/LoadM frame (2 header + 8 value)
//   - make_load_word : packs header and value into one LSB-first frame
package clk_prog_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_D    = 3'd1,
    GAP1      = 3'd2,
    LOAD_M    = 3'd3,
    GAP2      = 3'd4,
    GO        = 3'd5,
    WAIT_DONE = 3'd6,
    WAIT_LOCK = 3'd7
  } prog_state_e;

  localparam logic [1:0]  CMD_LOAD_D = 2'b01;
  localparam logic [1:0]  CMD_LOAD_M = 2'b11;
  localparam int unsigned LOAD_LEN   = 10;
  localparam int unsigned BIT_CNT_W  = 4;

  // Header occupies the low bits so it leaves the shifter first.
  function automatic logic [LOAD_LEN-1:0] make_load_word(input logic [1:0] cmd,
                                                         input logic [7:0] value);
    return {value, cmd};
  endfunction

endpackage

// File: rtl/clk_prog_shifter.sv
// 10-bit LSB-first shift register used for both the LoadD and LoadM frames.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_word, restart the bit count
//   load_word   : frame to send, bit0 first
//   shift_en    : advance one bit (zeros shift in from the top)
//   data_bit    : registered current bit (0 once the frame has drained)
//   last_bit    : high while the final bit of the frame is presented
module clk_prog_shifter
  import clk_prog_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [LOAD_LEN-1:0] load_word,
  input  logic                shift_en,
  output logic                data_bit,
  output logic                last_bit
);

  localparam logic [BIT_CNT_W-1:0] LAST_IDX = BIT_CNT_W'(LOAD_LEN - 1);

  logic [LOAD_LEN-1:0]  shift_r;
  logic [BIT_CNT_W-1:0] bit_cnt_r;

  // Frame register and bit position; draining to zero keeps PROGDATA low in gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else if (load) begin
      shift_r   <= load_word;
      bit_cnt_r <= '0;
    end else if (shift_en) begin
      shift_r   <= {1'b0, shift_r[LOAD_LEN-1:1]};
      bit_cnt_r <= (bit_cnt_r == LAST_IDX) ? '0 : bit_cnt_r + BIT_CNT_W'(1);
    end
  end

  assign data_bit = shift_r[0];
  assign last_bit = (bit_cnt_r == LAST_IDX);

endmodule

// File: rtl/dcm_clkgen_prog.sv
// Serial programmer for a Spartan-6 DCM_CLKGEN. Accepts an M/D request,
// shifts LoadD, LoadM and GO into the DCM, then waits for PROGDONE and LOCKED.
// Ports:
//   CLK, RST_N          : clock (also the DCM PROGCLK), async active-low reset
//   START_VALID/READY   : request handshake, READY high only in IDLE
//   MULT_M1, DIV_M1     : M-1 (1..255) and D-1 (0..255)
//   PROGEN, PROGDATA    : serial program port to the DCM (registered)
//   PROGDONE, LOCKED    : DCM status, only looked at in the wait states
//   BUSY, DONE, ERR     : sequencer busy, success pulse, sticky error
module dcm_clkgen_prog
  import clk_prog_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START_VALID,
  output logic       START_READY,
  input  logic [7:0] MULT_M1,
  input  logic [7:0] DIV_M1,
  output logic       PROGEN,
  output logic       PROGDATA,
  input  logic       PROGDONE,
  input  logic       LOCKED,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int unsigned     CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  prog_state_e         state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [7:0]          mult_r;
  logic                prog_en_r, busy_r, ready_r, done_r, err_r;
  logic                err_s, done_s, accept_s;
  logic                load_s, shift_en_s;
  logic [LOAD_LEN-1:0] load_word_s;
  logic                shift_bit_s, shift_last_s;

  assign accept_s = START_VALID && ready_r;

  clk_prog_shifter u_shifter (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (load_s),
    .load_word (load_word_s),
    .shift_en  (shift_en_s),
    .data_bit  (shift_bit_s),
    .last_bit  (shift_last_s)
  );

  // Next-state, shifter control and result flags.
  always_comb begin
    state_s     = state_r;
    err_s       = err_r;
    done_s      = 1'b0;
    load_s      = 1'b0;
    load_word_s = '0;
    shift_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          // M-1 of zero is rejected without touching the DCM port.
          if (MULT_M1 == 8'd0) begin
            err_s   = 1'b1;
            state_s = IDLE;
          end else begin
            err_s       = 1'b0;
            state_s     = LOAD_D;
            load_s      = 1'b1;
            load_word_s = make_load_word(CMD_LOAD_D, DIV_M1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_D: begin
        shift_en_s = 1'b1;
        if (shift_last_s) state_s = GAP1;
        else              state_s = LOAD_D;
      end
      GAP1: begin
        if (cnt_r == GAP_LAST) begin
          state_s     = LOAD_M;
          load_s      = 1'b1;
          load_word_s = make_load_word(CMD_LOAD_M, mult_r);
        end else begin
          state_s = GAP1;
        end
      end
      LOAD_M: begin
        shift_en_s = 1'b1;
        if (shift_last_s) state_s = GAP2;
        else              state_s = LOAD_M;
      end
      GAP2: begin
        if (cnt_r == GAP_LAST) state_s = GO;
        else                   state_s = GAP2;
      end
      GO: begin
        state_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A status hit in the final allowed cycle still wins over the timeout.
        if (PROGDONE) begin
          state_s = WAIT_LOCK;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      WAIT_LOCK: begin
        if (LOCKED) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else begin
          state_s = WAIT_LOCK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Gap/timeout counter: cleared on every state change and while idle, saturates.
  always_comb begin
    cnt_s = cnt_r;
    if ((state_s != state_r) || (state_r == IDLE)) begin
      cnt_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_s = cnt_r;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // State, counter, latched M and registered status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      mult_r    <= 8'd0;
      prog_en_r <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      mult_r    <= accept_s ? MULT_M1 : mult_r;
      prog_en_r <= (state_s == LOAD_D) || (state_s == LOAD_M) || (state_s == GO);
      busy_r    <= (state_s != IDLE);
      ready_r   <= (state_s == IDLE);
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  assign PROGEN      = prog_en_r;
  assign PROGDATA    = shift_bit_s;
  assign BUSY        = busy_r;
  assign START_READY = ready_r;
  assign DONE        = done_r;
  assign ERR         = err_r;

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
module tb_dcm_clkgen_prog;

  localparam int G  = 2;
  localparam int TO = 100;
  localparam int F  = 21 + 2 * G;   // first PROGEN cycle .. GO cycle
  localparam int NEVER = 1 << 30;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START_VALID = 1'b0;
  logic       START_READY;
  logic [7:0] MULT_M1 = 8'd0;
  logic [7:0] DIV_M1 = 8'd0;
  logic       PROGEN, PROGDATA;
  logic       PROGDONE = 1'b0;
  logic       LOCKED = 1'b0;
  logic       BUSY, DONE, ERR;

  int tests = 0;
  int fails = 0;

  // Expected {PROGEN, PROGDATA} for frame cycles 1..F
  logic [1:0] exp_q[$];

  dcm_clkgen_prog #(.GAP_CYCLES(G), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .START_VALID(START_VALID), .START_READY(START_READY),
    .MULT_M1(MULT_M1), .DIV_M1(DIV_M1), .PROGEN(PROGEN), .PROGDATA(PROGDATA),
    .PROGDONE(PROGDONE), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Frame as the DCM expects it: LoadD (1,0,D LSB first), gap, LoadM (1,1,M LSB first), gap, GO.
  task automatic build_frame(input logic [7:0] m, input logic [7:0] d);
    exp_q.delete();
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
    for (int i = 0; i < G; i++) exp_q.push_back(2'b00);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b11);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, m[i]});
    for (int i = 0; i < G; i++) exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // One request. pd_low: WAIT_DONE cycles seen with PROGDONE low before it rises (-1 = never).
  // lk_gap: cycles from PROGDONE rise to LOCKED rise (-1 = never).
  // hold: keep START_VALID high and scramble M/D during the frame.
  // Returns in the first IDLE cycle after the result.
  task automatic request(input string tag, input logic [7:0] m, input logic [7:0] d,
                         input int pd_low, input int lk_gap, input bit hold);
    int wd, wl, last_k, busy_cnt, done_cnt, pd_at, lk_at;
    bit ok;
    check({tag, "/accept_ready"}, START_READY, 1);
    START_VALID = 1'b1;
    MULT_M1 = m;
    DIV_M1 = d;
    if (m == 8'd0) begin
      tick();
      START_VALID = 1'b0;
      check({tag, "/illegal_err"}, ERR, 1);
      check({tag, "/illegal_ready"}, START_READY, 1);
      check({tag, "/illegal_busy"}, BUSY, 0);
      check({tag, "/illegal_progen"}, PROGEN, 0);
      for (int i = 0; i < 4; i++) begin
        tick();
        check({tag, "/illegal_quiet_progen"}, PROGEN, 0);
        check({tag, "/illegal_quiet_err"}, ERR, 1);
      end
      return;
    end
    build_frame(m, d);
    if (pd_low < 0 || pd_low + 1 > TO) begin
      wd = TO; wl = 0; ok = 1'b0;
    end else begin
      wd = pd_low + 1;
      if (lk_gap < 0 || lk_gap > TO) begin
        wl = TO; ok = 1'b0;
      end else begin
        wl = lk_gap; ok = 1'b1;
      end
    end
    last_k = F + wd + wl;
    pd_at = (pd_low < 0) ? NEVER : F + 1 + pd_low;
    lk_at = (pd_low < 0 || lk_gap < 0) ? NEVER : pd_at + lk_gap;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= last_k + 1; k++) begin
      tick();
      if (!hold) START_VALID = 1'b0;
      if (k <= F) begin
        // Status noise outside the wait states must be ignored.
        PROGDONE = 1'($urandom_range(0, 1));
        LOCKED = 1'($urandom_range(0, 1));
        if (hold) begin
          MULT_M1 = 8'($urandom);
          DIV_M1 = 8'($urandom);
        end
        check({tag, "/progen"}, PROGEN, exp_q[k-1][1]);
        check({tag, "/progdata"}, PROGDATA, exp_q[k-1][0]);
        check({tag, "/frame_busy"}, BUSY, 1);
        check({tag, "/frame_ready"}, START_READY, 0);
        check({tag, "/frame_done"}, DONE, 0);
        check({tag, "/frame_err"}, ERR, 0);
      end else if (k <= last_k) begin
        PROGDONE = (k >= pd_at);
        LOCKED = (k >= lk_at);
        check({tag, "/wait_progen"}, PROGEN, 0);
        check({tag, "/wait_progdata"}, PROGDATA, 0);
        check({tag, "/wait_busy"}, BUSY, 1);
        check({tag, "/wait_done"}, DONE, 0);
      end else begin
        PROGDONE = 1'b0;
        LOCKED = 1'b0;
        check({tag, "/end_busy"}, BUSY, 0);
        check({tag, "/end_ready"}, START_READY, 1);
        check({tag, "/end_done"}, DONE, ok);
        check({tag, "/end_err"}, ERR, !ok);
      end
      busy_cnt += int'(BUSY);
      done_cnt += int'(DONE);
    end
    check({tag, "/busy_cycles"}, busy_cnt, last_k);
    check({tag, "/done_pulses"}, done_cnt, ok ? 1 : 0);
  endtask

  initial begin
    logic [7:0] rm, rd;
    // Reset state
    tick();
    check("rst/progen", PROGEN, 0);
    check("rst/progdata", PROGDATA, 0);
    check("rst/busy", BUSY, 0);
    check("rst/done", DONE, 0);
    check("rst/err", ERR, 0);
    check("rst/ready", START_READY, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    tick();

    // Basic program: PROGDONE after 5 low cycles, LOCKED 20 cycles later -> 51 busy cycles
    request("basic", 8'h22, 8'h07, 5, 20, 1'b0);
    tick();
    check("basic/done_one_cycle", DONE, 0);

    // PROGDONE never returns
    request("to_done", 8'h40, 8'h01, -1, -1, 1'b0);
    // Next legal request clears ERR at accept; LOCKED never returns
    request("to_lock", 8'h11, 8'h00, 3, -1, 1'b0);
    // Illegal M
    request("illegal", 8'h00, 8'h05, 0, 1, 1'b0);

    // Back-pressure: valid held, M/D scrambled mid-frame
    request("bp1", 8'hA5, 8'h3C, 2, 3, 1'b1);
    request("bp2", 8'h01, 8'hFF, 0, 1, 1'b1);
    START_VALID = 1'b0;

    // Randomised legal requests
    for (int n = 0; n < 6; n++) begin
      rm = 8'($urandom_range(1, 255));
      rd = 8'($urandom_range(0, 255));
      request($sformatf("rnd%0d", n), rm, rd, int'($urandom_range(0, 8)),
              int'($urandom_range(1, 25)), 1'b0);
    end

    // Reset during LOAD_M bit 5
    build_frame(8'h5A, 8'h3C);
    START_VALID = 1'b1;
    MULT_M1 = 8'h5A;
    DIV_M1 = 8'h3C;
    for (int k = 1; k <= 16 + G; k++) begin
      tick();
      START_VALID = 1'b0;
    end
    check("mid_rst/pre_progen", PROGEN, exp_q[15 + G][1]);
    check("mid_rst/pre_progdata", PROGDATA, exp_q[15 + G][0]);
    RST_N = 1'b0;
    #1;
    check("mid_rst/async_progen", PROGEN, 0);
    check("mid_rst/async_progdata", PROGDATA, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check("mid_rst/ready", START_READY, 1);
    check("mid_rst/busy", BUSY, 0);
    check("mid_rst/err", ERR, 0);
    check("mid_rst/done", DONE, 0);
    check("mid_rst/progen", PROGEN, 0);

    // Re-issued request after reset completes normally
    request("post_rst", 8'h5A, 8'h3C, 1, 2, 1'b0);
    tick();
    check("post_rst/done_one_cycle", DONE, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
